// File: rtl/user_proj_mac_array_if.sv
// Wishbone slave bundle between the management SoC and the MAC array.
interface user_proj_mac_array_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic        ack;
  logic [31:0] rdat;

  modport master (output cyc, stb, we, sel, adr, wdat, input ack, rdat);
  modport slave  (input cyc, stb, we, sel, adr, wdat, output ack, rdat);
endinterface

// File: rtl/user_proj_mac_array.sv
// Multi-lane MAC accelerator: A/B operand buffers, LEN-step two-stage
// multiply/accumulate over LANES lanes, Wishbone register access, done irq.
module user_proj_mac_array #(
  parameter int          LANES    = 4,
  parameter int          DW       = 8,
  parameter int          ACCW     = 32,
  parameter int          DEPTH    = 16,
  parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_ni,
  user_proj_mac_array_if.slave  wbs,
  output logic [127:0]          la_data_out,
  output logic [2:0]            irq
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nx;

  logic [31:0]     a_mem [DEPTH];
  logic [31:0]     b_mem [DEPTH];
  logic [ACCW-1:0] acc [LANES];
  logic [ACCW-1:0] prod [LANES];
  logic [ACCW-1:0] prod_nx [LANES];
  logic            p_valid;
  logic [6:0]      len, step;
  logic            sgn, relu, irq_en, run_sgn, run_relu;
  logic            done, err, drain_cnt;
  logic            busy, run_en, set_done;

  logic        hit, req, wr;
  logic [1:0]  region;
  logic [5:0]  idx;
  logic        wr_ctrl, wr_stat, wr_len, wr_a, wr_b;
  logic        start_req, clr_req, len_ok, start_ok, start_err;
  logic [31:0] rd_data;
  logic [ACCW-1:0] acc_sel;
  logic        unused_adr;

  assign hit        = (wbs.adr[31:10] == BASE_ADR[31:10]);
  assign req        = wbs.cyc & wbs.stb & ~wbs.ack & hit;
  assign wr         = req & wbs.we;
  assign region     = wbs.adr[9:8];
  assign idx        = wbs.adr[7:2];
  assign unused_adr = &{1'b0, wbs.adr[1:0]};

  assign wr_ctrl = wr && (region == 2'd0) && (idx == 6'd0);
  assign wr_stat = wr && (region == 2'd0) && (idx == 6'd1);
  assign wr_len  = wr && (region == 2'd0) && (idx == 6'd2);
  assign wr_a    = wr && (region == 2'd1) && ({1'b0, idx} < 7'(DEPTH));
  assign wr_b    = wr && (region == 2'd2) && ({1'b0, idx} < 7'(DEPTH));

  assign start_req = wr_ctrl & wbs.sel[0] & wbs.wdat[0] & ~busy;
  assign clr_req   = wr_ctrl & wbs.sel[0] & wbs.wdat[1] & ~busy;
  assign len_ok    = (len != 7'd0) && (len <= 7'(DEPTH));
  assign start_ok  = start_req & len_ok;
  assign start_err = start_req & ~len_ok;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) state <= IDLE;
    else            state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_ok) state_nx = RUN;
      RUN:     if (step == len - 7'd1) state_nx = DRAIN;
      DRAIN:   if (drain_cnt) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    run_en   = (state == RUN);
    set_done = (state == DRAIN) && drain_cnt;
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      wbs.ack   <= 1'b0;
      wbs.rdat  <= '0;
      len       <= '0;
      sgn       <= 1'b0;
      relu      <= 1'b0;
      irq_en    <= 1'b0;
      run_sgn   <= 1'b0;
      run_relu  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      step      <= '0;
      drain_cnt <= 1'b0;
    end else begin
      wbs.ack  <= req;
      wbs.rdat <= (req & ~wbs.we) ? rd_data : '0;
      if (wr_ctrl && wbs.sel[0]) begin
        irq_en <= wbs.wdat[4];
        if (!busy) begin
          sgn  <= wbs.wdat[2];
          relu <= wbs.wdat[3];
        end
      end
      if (wr_len && wbs.sel[0] && !busy) len <= wbs.wdat[6:0];
      if (start_ok) begin
        run_sgn  <= wbs.wdat[2];
        run_relu <= wbs.wdat[3];
      end
      if (start_ok)    step <= '0;
      else if (run_en) step <= step + 7'd1;
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
      // A completing run beats a same-cycle DONE clear.
      if (set_done)                                      done <= 1'b1;
      else if (start_ok)                                 done <= 1'b0;
      else if (wr_stat && wbs.sel[0] && wbs.wdat[1])     done <= 1'b0;
      if (start_err)                                     err <= 1'b1;
      else if (wr_stat && wbs.sel[0] && wbs.wdat[2])     err <= 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    for (int unsigned b = 0; b < 4; b++) begin
      if (wr_a && !busy && wbs.sel[b]) a_mem[idx[AW-1:0]][8*b +: 8] <= wbs.wdat[8*b +: 8];
      if (wr_b && !busy && wbs.sel[b]) b_mem[idx[AW-1:0]][8*b +: 8] <= wbs.wdat[8*b +: 8];
    end
  end

  logic [DW-1:0]          oa, ob;
  logic signed [2*DW-1:0] sp;
  logic [2*DW-1:0]        up;

  always_comb begin
    oa = '0;
    ob = '0;
    sp = '0;
    up = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      oa = a_mem[step[AW-1:0]][i*DW +: DW];
      ob = b_mem[step[AW-1:0]][i*DW +: DW];
      sp = $signed({{DW{oa[DW-1]}}, oa}) * $signed({{DW{ob[DW-1]}}, ob});
      up = {{DW{1'b0}}, oa} * {{DW{1'b0}}, ob};
      prod_nx[i] = run_sgn ? ACCW'(sp) : ACCW'(up);
    end
  end

  // Stage 1 registers the lane products, stage 2 folds them into acc.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      p_valid <= 1'b0;
      for (int unsigned i = 0; i < LANES; i++) begin
        prod[i] <= '0;
        acc[i]  <= '0;
      end
    end else begin
      p_valid <= run_en;
      for (int unsigned i = 0; i < LANES; i++) begin
        if (run_en) prod[i] <= prod_nx[i];
        if (clr_req)      acc[i] <= '0;
        else if (p_valid) acc[i] <= acc[i] + prod[i];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    acc_sel = acc[idx[LW-1:0]];
    case (region)
      2'd0: begin
        case (idx)
          6'd0:    rd_data = {27'd0, irq_en, relu, sgn, 2'b00};
          6'd1:    rd_data = {29'd0, err, done, busy};
          6'd2:    rd_data = {25'd0, len};
          default: rd_data = '0;
        endcase
      end
      2'd1: if ({1'b0, idx} < 7'(DEPTH)) rd_data = a_mem[idx[AW-1:0]];
      2'd2: if ({1'b0, idx} < 7'(DEPTH)) rd_data = b_mem[idx[AW-1:0]];
      default: begin
        if ({1'b0, idx} < 7'(LANES))
          rd_data = (run_sgn & run_relu & acc_sel[ACCW-1]) ? '0 : 32'(acc_sel);
      end
    endcase
  end

  assign la_data_out = {118'd0, step[5:0], 1'b0, err, done, busy};
  assign irq         = {2'b00, done & irq_en};
endmodule

// File: tb/tb_user_proj_mac_array.sv
// Scoreboard bench for user_proj_mac_array: reads queue expected data,
// the ack monitor pops and compares.
module tb_user_proj_mac_array;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  user_proj_mac_array_if wbs();
  logic [127:0] la;
  logic [2:0]   irq;

  user_proj_mac_array #(
    .LANES(4), .DW(8), .ACCW(32), .DEPTH(16), .BASE_ADR(32'h3000_0000)
  ) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs(wbs), .la_data_out(la), .irq(irq)
  );

  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam logic [31:0] CTRL  = BASE + 32'h000;
  localparam logic [31:0] STAT  = BASE + 32'h004;
  localparam logic [31:0] LENR  = BASE + 32'h008;
  localparam logic [31:0] ABUF  = BASE + 32'h100;
  localparam logic [31:0] BBUF  = BASE + 32'h200;
  localparam logic [31:0] ACC   = BASE + 32'h300;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q [$];
  string       tag_q [$];
  logic [31:0] mon_exp;
  string       mon_tag;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wbs.ack === 1'b1 && wbs.we === 1'b0) begin
      if (exp_q.size() == 0) check("rd_queue", exp_q.size(), 1);
      else begin
        mon_exp = exp_q.pop_front();
        mon_tag = tag_q.pop_front();
        check(mon_tag, wbs.rdat, mon_exp);
      end
    end
  end

  task automatic wb_cycle(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel);
    logic acked;
    @(posedge clk); #1;
    wbs.cyc = 1'b1; wbs.stb = 1'b1; wbs.we = we;
    wbs.adr = adr;  wbs.wdat = dat; wbs.sel = sel;
    acked = 1'b0;
    for (int n = 0; n < 16 && !acked; n++) begin
      @(negedge clk);
      acked = wbs.ack;
    end
    if (!acked) check("ack_timeout", wbs.ack, 1'b1);
    @(posedge clk); #1;
    wbs.cyc = 1'b0; wbs.stb = 1'b0; wbs.we = 1'b0;
  endtask

  task automatic wb_wr(input logic [31:0] adr, input logic [31:0] dat);
    wb_cycle(1'b1, adr, dat, 4'hF);
  endtask

  task automatic wb_rd(input logic [31:0] adr, input logic [31:0] exp, input string tag);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    wb_cycle(1'b0, adr, 32'd0, 4'hF);
  endtask

  // Returns one cycle after the START ack edge; counts on to DONE.
  task automatic run_ctrl(input logic [31:0] ctrl, input int lat, input string tag);
    int c;
    wb_wr(CTRL, ctrl);
    check({tag, "_busy"}, la[0], 1'b1);
    c = 1;
    while (la[1] !== 1'b1 && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    check({tag, "_latency"}, c, lat);
  endtask

  task automatic poll_done(input string tag);
    int c;
    c = 0;
    while (la[1] !== 1'b1 && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    check(tag, la[1], 1'b1);
  endtask

  task automatic rd_accs(input logic [31:0] e0, input logic [31:0] e1,
                         input logic [31:0] e2, input logic [31:0] e3, input string tag);
    wb_rd(ACC + 32'h0, e0, {tag, "_acc0"});
    wb_rd(ACC + 32'h4, e1, {tag, "_acc1"});
    wb_rd(ACC + 32'h8, e2, {tag, "_acc2"});
    wb_rd(ACC + 32'hC, e3, {tag, "_acc3"});
  endtask

  initial begin
    int c;
    wbs.cyc = 1'b0; wbs.stb = 1'b0; wbs.we = 1'b0;
    wbs.sel = 4'h0; wbs.adr = '0; wbs.wdat = '0;

    // reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", wbs.ack, 1'b0);
    check("rst_irq", irq, 3'b000);
    check("rst_la", la, 128'd0);
    rst_n = 1'b1;
    wb_rd(STAT, 32'h0, "rst_status");
    wb_rd(LENR, 32'h0, "rst_len");
    wb_rd(CTRL, 32'h0, "rst_ctrl");
    rd_accs(0, 0, 0, 0, "rst");
    wb_rd(BASE + 32'h00C, 32'h0, "unmapped_reg");
    wb_rd(ACC + 32'h3C, 32'h0, "unmapped_acc");

    // unsigned single step with irq
    wb_wr(ABUF, 32'h0403_0201);
    wb_wr(BBUF, 32'h0202_0202);
    wb_wr(LENR, 32'd1);
    run_ctrl(32'h11, 3, "t2");
    check("t2_irq", irq, 3'b001);
    rd_accs(2, 4, 6, 8, "t2");
    wb_rd(STAT, 32'h2, "t2_status");
    wb_wr(STAT, 32'h2);
    check("t2_irq_clr", irq, 3'b000);
    wb_rd(STAT, 32'h0, "t2_status_clr");
    wb_cycle(1'b1, ABUF, 32'h0000_00AA, 4'b0001);
    wb_rd(ABUF, 32'h0403_02AA, "byte_merge");

    // signed, relu readout, unsigned reinterpretation
    wb_wr(CTRL, 32'h02);
    rd_accs(0, 0, 0, 0, "clr");
    wb_wr(ABUF, 32'h0000_00FF);
    wb_wr(BBUF, 32'h0000_0005);
    run_ctrl(32'h05, 3, "t3s");
    rd_accs(32'hFFFF_FFFB, 0, 0, 0, "t3s");
    run_ctrl(32'h0F, 3, "t3r");
    wb_rd(ACC, 32'h0, "t3_relu_acc0");
    run_ctrl(32'h03, 3, "t3u");
    wb_rd(ACC, 32'h0000_04FB, "t3_unsigned_acc0");

    // length errors; DONE from the previous run stays set
    wb_wr(LENR, 32'd0);
    wb_wr(CTRL, 32'h01);
    for (int i = 0; i < 3; i++) begin
      check("t4_len0_busy", la[0], 1'b0);
      @(posedge clk); #1;
    end
    wb_rd(STAT, 32'h6, "t4_len0_status");
    wb_wr(STAT, 32'h4);
    wb_rd(STAT, 32'h2, "t4_err_w1c");
    wb_wr(LENR, 32'hFFFF_FF91);
    wb_rd(LENR, 32'h11, "t4_len_mask");
    wb_wr(CTRL, 32'h01);
    check("t4_len17_busy", la[0], 1'b0);
    wb_rd(STAT, 32'h6, "t4_len17_status");
    wb_wr(STAT, 32'h6);
    wb_rd(STAT, 32'h0, "t4_clear_all");

    // full depth, all-ones unsigned
    for (int k = 0; k < 16; k++) begin
      wb_wr(ABUF + 32'(4 * k), 32'hFFFF_FFFF);
      wb_wr(BBUF + 32'(4 * k), 32'hFFFF_FFFF);
    end
    wb_wr(LENR, 32'd16);
    run_ctrl(32'h03, 18, "t5a");
    rd_accs(32'hFE010, 32'hFE010, 32'hFE010, 32'hFE010, "t5a");
    run_ctrl(32'h01, 18, "t5b");
    rd_accs(32'h1FC020, 32'h1FC020, 32'h1FC020, 32'h1FC020, "t5b");

    // writes while busy: only IRQ_EN lands
    wb_wr(CTRL, 32'h03);
    wb_wr(BBUF, 32'h0);
    wb_wr(LENR, 32'd1);
    wb_wr(CTRL, 32'h13);
    check("t6_still_busy", la[0], 1'b1);
    poll_done("t6_done");
    check("t6_irq", irq, 3'b001);
    rd_accs(32'hFE010, 32'hFE010, 32'hFE010, 32'hFE010, "t6");
    wb_rd(BBUF, 32'hFFFF_FFFF, "t6_b0_kept");
    wb_rd(LENR, 32'd16, "t6_len_kept");

    // reset in the middle of a run
    wb_wr(STAT, 32'h2);
    wb_wr(CTRL, 32'h01);
    c = 0;
    while (la[9:4] !== 6'd5 && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    check("t6_reach_step5", la[9:4], 6'd5);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("t6_rst_la", la, 128'd0);
    check("t6_rst_irq", irq, 3'b000);
    rst_n = 1'b1;
    rd_accs(0, 0, 0, 0, "t6_rst");
    wb_rd(STAT, 32'h0, "t6_rst_status");

    repeat (2) @(posedge clk);
    check("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
